apb_i2c_arbiter: RTL and testbench

//  Two-port APB master arbiter in front of the APB-to-I2C slave. Shares the

---
 rtl/apb_i2c_arbiter.sv | 156 +++++++++++++++
 tb/tb_apb_i2c_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_i2c_arbiter.sv
// Two-requester round-robin APB master in front of the APB-to-I2C slave.
// Runs SETUP/ACCESS phases, returns read data/status, and aborts stalled accesses.
module apb_i2c_arbiter #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [1:0]  REQ_VALID,
  input  logic [1:0]  REQ_WRITE,
  input  logic [63:0] REQ_ADDR,
  input  logic [63:0] REQ_WDATA,
  output logic [1:0]  REQ_GNT,
  output logic [1:0]  RSP_VALID,
  output logic [31:0] RSP_RDATA,
  output logic        RSP_ERR,
  output logic        PSELx,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int unsigned CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d, wait_inc;
  logic             last_q, last_d, winner;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             psel_q, psel_d;
  logic             penable_q, penable_d;
  logic             pwrite_q, pwrite_d;
  logic [31:0]      paddr_q, paddr_d;
  logic [31:0]      pwdata_q, pwdata_d;

  // last_q doubles as the owner of the transfer in flight.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    wait_inc    = wait_cnt_q + CNT_W'(1);
    last_d      = last_q;
    winner      = last_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    case (state_q)
      ST_IDLE: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        if (|REQ_VALID) begin
          winner        = (REQ_VALID == 2'b11) ? ~last_q : REQ_VALID[1];
          last_d        = winner;
          gnt_d[winner] = 1'b1;
          psel_d        = 1'b1;
          pwrite_d      = REQ_WRITE[winner];
          paddr_d       = winner ? REQ_ADDR[63:32]  : REQ_ADDR[31:0];
          pwdata_d      = winner ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
          state_d       = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d  = 1'b1;
        wait_cnt_d = '0;
        state_d    = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          psel_d              = 1'b0;
          penable_d           = 1'b0;
          rsp_valid_d[last_q] = 1'b1;
          rsp_rdata_d         = pwrite_q ? '0 : PRDATA;
          rsp_err_d           = PSLVERR;
          state_d             = ST_RESP;
        end else begin
          wait_cnt_d = wait_inc;
          // Watchdog: unmapped addresses never raise PREADY and end up here.
          if (wait_inc == CNT_W'(WAIT_MAX)) begin
            psel_d              = 1'b0;
            penable_d           = 1'b0;
            rsp_valid_d[last_q] = 1'b1;
            rsp_err_d           = 1'b1;
            state_d             = ST_RESP;
          end
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!PRESETn) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= '0;
      last_q      <= 1'b1;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  assign REQ_GNT   = gnt_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_RDATA = rsp_rdata_q;
  assign RSP_ERR   = rsp_err_q;
  assign PSELx     = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_i2c_arbiter.sv
// Bench for apb_i2c_arbiter: transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_i2c_arbiter;

  localparam int WAIT_MAX = 16;
  localparam int STUCK    = 1000;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [1:0]  REQ_VALID, REQ_WRITE, REQ_GNT, RSP_VALID;
  logic [63:0] REQ_ADDR, REQ_WDATA;
  logic [31:0] RSP_RDATA, PADDR, PWDATA, PRDATA;
  logic        RSP_ERR, PSELx, PENABLE, PWRITE, PREADY, PSLVERR;

  apb_i2c_arbiter #(.WAIT_MAX(WAIT_MAX)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .REQ_GNT(REQ_GNT), .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
    .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Stimulus knobs
  logic        stim_rst = 1'b0;
  logic [1:0]  stim_valid = '0, stim_write = '0, hold = '0;
  logic [31:0] stim_addr [2];
  logic [31:0] stim_wdata [2];
  bit          rand_mode = 1'b0;
  int          force_w = -1, force_err = -1, pslverr_other = -1;
  bit          prdata_fixed = 1'b0;
  logic [31:0] prdata_fix = '0;

  // Model: one transfer record as a timeline of cycle numbers
  bit          m_active = 1'b0, m_owner = 1'b0, m_abort = 1'b0, m_last = 1'b1, m_err_plan = 1'b0;
  int          m_start = 0, m_acc_end = 0, m_resp = 0;
  logic        m_wr = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick_addr();
    logic [2:0] r;
    r = 3'($urandom_range(0, 7));
    return (r == 3'd7) ? 32'h0000_0020 : {28'd0, r[1:0], 2'b00};
  endfunction

  function automatic bit model_busy();
    return m_active && (cyc <= m_resp);
  endfunction

  task automatic drive();
    bit          in_acc, done, win, mapped;
    logic [31:0] prd;
    logic        rdy, slv;
    int          w;
    if (rand_mode) begin
      for (int j = 0; j < 2; j++) begin
        if (!stim_valid[j] && $urandom_range(0, 3) == 0) stim_valid[j] = 1'b1;
        stim_write[j] = 1'($urandom_range(0, 1));
        stim_addr[j]  = pick_addr();
        stim_wdata[j] = $urandom;
        hold[j]       = ($urandom_range(0, 3) == 0);
      end
      stim_rst = ($urandom_range(0, 149) != 0);
    end
    if (m_active && cyc == m_start && !hold[m_owner]) stim_valid[m_owner] = 1'b0;

    in_acc = m_active && cyc > m_start && cyc <= m_acc_end;
    done   = in_acc && !m_abort && cyc == m_acc_end;
    prd    = prdata_fixed ? prdata_fix : $urandom;
    rdy    = done ? 1'b1 : (in_acc ? 1'b0 : 1'($urandom_range(0, 1)));
    slv    = done ? m_err_plan : ((pslverr_other < 0) ? 1'($urandom_range(0, 1)) : (pslverr_other != 0));
    if (done) begin
      m_rdata = m_wr ? 32'd0 : prd;
      m_err   = m_err_plan;
    end

    PRESETn   = stim_rst;
    REQ_VALID = stim_valid;
    REQ_WRITE = stim_write;
    REQ_ADDR  = {stim_addr[1], stim_addr[0]};
    REQ_WDATA = {stim_wdata[1], stim_wdata[0]};
    PRDATA    = prd;
    PREADY    = rdy;
    PSLVERR   = slv;

    if (!stim_rst) begin
      m_active = 1'b0; m_last = 1'b1;
      m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    end else if (!model_busy() && stim_valid != 2'b00) begin
      win        = (stim_valid == 2'b11) ? ~m_last : stim_valid[1];
      m_last     = win;
      m_owner    = win;
      m_wr       = stim_write[win];
      m_addr     = stim_addr[win];
      m_wdata    = stim_wdata[win];
      m_start    = cyc + 1;
      m_active   = 1'b1;
      mapped     = (m_addr inside {32'd0, 32'd4, 32'd8, 32'd12});
      if (!mapped)           w = STUCK;
      else if (force_w >= 0) w = force_w;
      else begin
        case ($urandom_range(0, 9))
          6, 7, 8: w = $urandom_range(1, 4);
          9:       w = $urandom_range(WAIT_MAX - 1, WAIT_MAX);
          default: w = 0;
        endcase
      end
      m_err_plan = (force_err >= 0) ? (force_err != 0) : ($urandom_range(0, 3) == 0);
      if (w < WAIT_MAX) begin
        m_acc_end = m_start + 1 + w;
        m_abort   = 1'b0;
      end else begin
        m_acc_end = m_start + WAIT_MAX;
        m_abort   = 1'b1;
        m_rdata   = '0;
        m_err     = 1'b1;
      end
      m_resp = m_acc_end + 1;
    end
  endtask

  task automatic compare();
    logic [1:0] hot, e_gnt, e_rv;
    logic       e_psel, e_pen;
    hot    = m_owner ? 2'b10 : 2'b01;
    e_gnt  = (m_active && cyc == m_start) ? hot : 2'b00;
    e_rv   = (m_active && cyc == m_resp)  ? hot : 2'b00;
    e_psel = m_active && cyc >= m_start && cyc <= m_acc_end;
    e_pen  = m_active && cyc >  m_start && cyc <= m_acc_end;
    check("gnt",       32'(REQ_GNT),   32'(e_gnt));
    check("psel",      32'(PSELx),     32'(e_psel));
    check("penable",   32'(PENABLE),   32'(e_pen));
    check("pwrite",    32'(PWRITE),    32'(m_wr));
    check("paddr",     PADDR,          m_addr);
    check("pwdata",    PWDATA,         m_wdata);
    check("rsp_valid", 32'(RSP_VALID), 32'(e_rv));
    check("rsp_rdata", RSP_RDATA,      (e_rv != 0) ? m_rdata : 32'd0);
    check("rsp_err",   32'(RSP_ERR),   32'((e_rv != 0) ? m_err : 1'b0));
  endtask

  task automatic step();
    drive();
    @(posedge PCLK);
    #1;
    cyc++;
    compare();
  endtask

  task automatic idle_wait();
    for (int i = 0; i < 80; i++) begin
      if (!model_busy()) break;
      step();
    end
  endtask

  task automatic run_to_rsp(output bit got, output int n_acc);
    got = 1'b0; n_acc = 0;
    for (int i = 0; i < 40; i++) begin
      if (RSP_VALID != 2'b00) begin got = 1'b1; break; end
      if (PSELx && PENABLE) n_acc++;
      step();
    end
  endtask

  task automatic knobs_default();
    force_w = -1; force_err = -1; pslverr_other = -1; prdata_fixed = 1'b0;
    hold = 2'b00; stim_valid = 2'b00;
  endtask

  initial begin
    bit   got;
    int   n_acc, ng, quiet_bad;
    logic [1:0] g_val [4];
    int   g_cyc [4];
    stim_addr[0] = '0; stim_addr[1] = '0; stim_wdata[0] = '0; stim_wdata[1] = '0;

    // Reset state
    stim_rst = 1'b0;
    step(); step();
    check("rst_psel", 32'(PSELx), 32'd0);
    check("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    stim_rst = 1'b1;

    // T2: both valid from reset, held: grants alternate starting with req0
    stim_valid = 2'b11; stim_write = 2'b00; hold = 2'b11; force_w = 0;
    stim_addr[0] = 32'd4; stim_addr[1] = 32'd4;
    ng = 0;
    for (int i = 0; i < 4; i++) begin g_val[i] = '0; g_cyc[i] = 0; end
    for (int i = 0; i < 40 && ng < 4; i++) begin
      step();
      if (REQ_GNT != 2'b00) begin g_val[ng] = REQ_GNT; g_cyc[ng] = cyc; ng++; end
    end
    check("t2_grants_seen", 32'(ng), 32'd4);
    check("t2_gnt0", 32'(g_val[0]), 32'd1);
    check("t2_gnt1", 32'(g_val[1]), 32'd2);
    check("t2_gnt2", 32'(g_val[2]), 32'd1);
    check("t2_gnt3", 32'(g_val[3]), 32'd2);
    check("t2_spacing", 32'(g_cyc[1] - g_cyc[0]), 32'd4);
    knobs_default(); idle_wait();

    // T1: req0 write A=8, zero wait states
    stim_valid = 2'b01; stim_write = 2'b01; stim_addr[0] = 32'h8; stim_wdata[0] = 32'h0000_2A5F;
    force_w = 0; force_err = 0;
    step();
    check("t1_gnt", 32'(REQ_GNT), 32'd1);
    check("t1_psel_setup", 32'(PSELx), 32'd1);
    check("t1_pen_setup", 32'(PENABLE), 32'd0);
    check("t1_paddr", PADDR, 32'h8);
    check("t1_pwdata", PWDATA, 32'h0000_2A5F);
    step();
    check("t1_psel_access", 32'(PSELx), 32'd1);
    check("t1_pen_access", 32'(PENABLE), 32'd1);
    step();
    check("t1_rsp", 32'(RSP_VALID), 32'd1);
    check("t1_err", 32'(RSP_ERR), 32'd0);
    check("t1_psel_done", 32'(PSELx), 32'd0);
    step();
    check("t1_rsp_pulse", 32'(RSP_VALID), 32'd0);
    knobs_default(); idle_wait();

    // T3: req1 read A=4 returns slave data
    stim_valid = 2'b10; stim_write = 2'b00; stim_addr[1] = 32'd4;
    force_w = 0; force_err = 0; prdata_fixed = 1'b1; prdata_fix = 32'hDEAD_BEEF;
    step(); step(); step();
    check("t3_rsp", 32'(RSP_VALID), 32'd2);
    check("t3_rdata", RSP_RDATA, 32'hDEAD_BEEF);
    check("t3_err", 32'(RSP_ERR), 32'd0);
    knobs_default(); idle_wait();

    // T4: unmapped write -> watchdog abort after WAIT_MAX access cycles
    stim_valid = 2'b01; stim_write = 2'b01; stim_addr[0] = 32'h20; stim_wdata[0] = 32'h1234_5678;
    step();
    run_to_rsp(got, n_acc);
    check("t4_rsp_seen", 32'(got), 32'd1);
    check("t4_access_cycles", 32'(n_acc), 32'd16);
    check("t4_err", 32'(RSP_ERR), 32'd1);
    check("t4_rdata", RSP_RDATA, 32'd0);
    check("t4_psel_low", 32'(PSELx), 32'd0);
    knobs_default(); idle_wait();

    // T5: PSLVERR at completion vs PSLVERR only during wait cycles
    stim_valid = 2'b01; stim_write = 2'b00; stim_addr[0] = 32'd0; force_w = 2; force_err = 1;
    step();
    run_to_rsp(got, n_acc);
    check("t5a_rsp_seen", 32'(got), 32'd1);
    check("t5a_access_cycles", 32'(n_acc), 32'd3);
    check("t5a_err", 32'(RSP_ERR), 32'd1);
    knobs_default(); idle_wait();
    stim_valid = 2'b01; stim_write = 2'b01; stim_addr[0] = 32'd12; force_w = 3; force_err = 0; pslverr_other = 1;
    step();
    run_to_rsp(got, n_acc);
    check("t5b_rsp_seen", 32'(got), 32'd1);
    check("t5b_access_cycles", 32'(n_acc), 32'd4);
    check("t5b_err", 32'(RSP_ERR), 32'd0);
    knobs_default(); idle_wait();

    // T6: reset during ACCESS drops the transfer; req0 wins afterwards
    stim_valid = 2'b01; stim_write = 2'b00; stim_addr[0] = 32'd8; force_w = 5;
    step(); step(); step();
    check("t6_in_access", 32'(PENABLE), 32'd1);
    stim_rst = 1'b0;
    step();
    check("t6_psel", 32'(PSELx), 32'd0);
    check("t6_penable", 32'(PENABLE), 32'd0);
    check("t6_paddr", PADDR, 32'd0);
    check("t6_gnt", 32'(REQ_GNT), 32'd0);
    check("t6_rsp", 32'(RSP_VALID), 32'd0);
    stim_rst = 1'b1; stim_valid = 2'b00;
    quiet_bad = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (RSP_VALID != 2'b00) quiet_bad++;
    end
    check("t6_no_rsp_after_reset", 32'(quiet_bad), 32'd0);
    stim_valid = 2'b11; stim_addr[0] = 32'd0; stim_addr[1] = 32'd4;
    step();
    check("t6_req0_first", 32'(REQ_GNT), 32'd1);
    knobs_default(); idle_wait();

    // Randomized traffic against the model
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    stim_rst = 1'b1;
    knobs_default();
    idle_wait();
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
